// File: rtl/switch_pkg.sv
// switch_pkg: shared types and constants for the 4-port switch.
//   pkt_t        packet word {source[3:0], target[3:0], data[7:0]}
//   out_state_e  egress output register state (IDLE / HOLD)
//   NUM_PORTS    number of switch ports
package switch_pkg;

  localparam int NUM_PORTS = 4;

  typedef struct packed {
    logic [3:0] source;
    logic [3:0] target;
    logic [7:0] data;
  } pkt_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } out_state_e;

endpackage

// File: rtl/egress_fifo.sv
// egress_fifo: circular-buffer FIFO used per source inside the egress port.
// Pointers carry one extra MSB so that full and empty can be told apart.
//   clk, rst_n  clock / asynchronous active-low reset
//   push, din   write request and data (ignored when full)
//   pop, dout   read request (ignored when empty) and head-of-queue data
//   full, empty registered-state status flags
module egress_fifo
  import switch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = pkt_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push_s;
  logic        do_pop_s;
  T            mem_q [DEPTH];

  // Status flags and pointer advance; pointers wrap modulo 2*DEPTH naturally.
  always_comb begin
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty     = (wr_ptr_q == rd_ptr_q);
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    dout = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only read while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/switch_egress_port.sv
// switch_egress_port: output stage of one switch port.
// Per-source FIFOs collect packets routed to this port; a round-robin
// arbiter merges them into a single registered output stream. Packets whose
// target bit for this port is clear are accepted and dropped (counted).
//   clk, rst_n          clock / asynchronous active-low reset
//   in_valid/in_ready   per-source handshake (ready = that FIFO not full)
//   in_pkt              per-source packet
//   out_valid/out_ready output handshake, out_pkt output packet
//   pkt_cnt, drop_cnt   saturating delivered / dropped counters
module switch_egress_port
  import switch_pkg::*;
#(
  parameter int PORT_ID    = 0,
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   in_valid,
  output logic [NUM_SRC-1:0]   in_ready,
  input  pkt_t [NUM_SRC-1:0]   in_pkt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output pkt_t                 out_pkt,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // First requester at or after ptr, wrapping: masked pick, else plain pick.
  function automatic logic [SW-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                            input logic [SW-1:0]      ptr);
    logic [NUM_SRC-1:0] masked;
    logic               found;
    logic [SW-1:0]      idx;
    masked = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      masked[i] = req[i] && (i >= int'(ptr));
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && masked[i]) begin
        idx   = SW'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && req[i]) begin
        idx   = SW'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

  // Number of set bits, widened by one so a saturating add can see overflow.
  function automatic logic [CNT_W:0] popcnt(input logic [NUM_SRC-1:0] v);
    logic [CNT_W:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sum = sum + (CNT_W+1)'(v[i]);
    end
    return sum;
  endfunction

  logic [NUM_SRC-1:0] fifo_push_s;
  logic [NUM_SRC-1:0] fifo_pop_s;
  logic [NUM_SRC-1:0] fifo_full_s;
  logic [NUM_SRC-1:0] fifo_empty_s;
  pkt_t               fifo_dout_s [NUM_SRC];
  logic [NUM_SRC-1:0] drop_s;
  logic [NUM_SRC-1:0] req_s;
  logic               any_req_s;
  logic [SW-1:0]      grant_s;
  logic               load_s;
  logic               deliver_s;
  logic [CNT_W:0]     drop_sum_s;

  out_state_e         state_q, state_d;
  logic               out_valid_q, out_valid_d;
  pkt_t               out_pkt_q, out_pkt_d;
  logic [SW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
    egress_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (pkt_t)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push_s[g]),
      .pop   (fifo_pop_s[g]),
      .din   (in_pkt[g]),
      .dout  (fifo_dout_s[g]),
      .full  (fifo_full_s[g]),
      .empty (fifo_empty_s[g])
    );
  end

  // Ready depends on registered FIFO state only, so a full FIFO refuses a
  // push even when it is being popped in the same cycle.
  assign in_ready = ~fifo_full_s;

  // Accepted packets go to their FIFO when routed here, otherwise are dropped.
  always_comb begin
    fifo_push_s = '0;
    drop_s      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (in_valid[i] && !fifo_full_s[i]) begin
        fifo_push_s[i] = in_pkt[i].target[PORT_ID];
        drop_s[i]      = !in_pkt[i].target[PORT_ID];
      end else begin
        fifo_push_s[i] = 1'b0;
        drop_s[i]      = 1'b0;
      end
    end
    req_s     = ~fifo_empty_s;
    any_req_s = |req_s;
    grant_s   = rr_pick(req_s, rr_ptr_q);
  end

  // Output FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output FSM next state: leave HOLD only when the held packet is taken and
  // nothing is queued to replace it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (out_ready && !any_req_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output FSM outputs: a load pops the granted FIFO into the output register,
  // either from IDLE or in the same cycle the held packet is accepted.
  always_comb begin
    fifo_pop_s  = '0;
    out_pkt_d   = out_pkt_q;
    rr_ptr_d    = rr_ptr_q;
    load_s      = any_req_s && ((state_q == ST_IDLE) || out_ready);
    out_valid_d = (state_d == ST_HOLD);
    if (load_s) begin
      fifo_pop_s[grant_s] = 1'b1;
      out_pkt_d           = fifo_dout_s[grant_s];
      if (grant_s == SW'(NUM_SRC - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_s + SW'(1'b1);
      end
    end else begin
      out_pkt_d = out_pkt_q;
      rr_ptr_d  = rr_ptr_q;
    end
  end

  // Saturating statistics counters.
  always_comb begin
    deliver_s  = out_valid_q && out_ready;
    drop_sum_s = {1'b0, drop_cnt_q} + popcnt(drop_s);
    if (deliver_s && (pkt_cnt_q != {CNT_W{1'b1}})) begin
      pkt_cnt_d = pkt_cnt_q + CNT_W'(1'b1);
    end else begin
      pkt_cnt_d = pkt_cnt_q;
    end
    if (drop_sum_s[CNT_W]) begin
      drop_cnt_d = {CNT_W{1'b1}};
    end else begin
      drop_cnt_d = drop_sum_s[CNT_W-1:0];
    end
  end

  // Output datapath, arbitration pointer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
      rr_ptr_q    <= '0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pkt_q   <= out_pkt_d;
      rr_ptr_q    <= rr_ptr_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pkt   = out_pkt_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
